// File: rtl/ndelay_pkg.sv
// Shared constants and elaboration helpers for the variable-length delay line.
package ndelay_pkg;

  localparam int DLY_MIN = 1;

  // Constant-foldable ceil(log2(value)), used to size the delay selector.
  function automatic int ndelay_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic bit ndelay_params_ok(input int maxDelays, input int delays);
    return (maxDelays >= 2) && (delays >= DLY_MIN) && (delays <= maxDelays);
  endfunction

endpackage

// File: rtl/ndelay_stage.sv
// One tap of the delay line: a data register plus its valid flag.
module ndelay_stage
  import ndelay_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_valid,
  input  logic [WIDTH-1:0] d,
  input  logic             dv,
  output logic [WIDTH-1:0] q,
  output logic             qv
);

  // Data is don't-care when the valid is cleared, so it keeps shifting on en.
  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= '0;
      qv <= 1'b0;
    end else begin
      if (en) q <= d;
      if (clr_valid) qv <= 1'b0;
      else if (en)   qv <= dv;
    end
  end

endmodule

// File: rtl/ndelay_ctrl.sv
// Delay line with run-time selectable length, stall, flush and delay-load control.
module ndelay_ctrl
  import ndelay_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_DELAYS = 16,
  parameter int DELAYS     = 2,
  parameter int DW         = ndelay_clog2(MAX_DELAYS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] dinput,
  input  logic             dly_load,
  input  logic [DW-1:0]    dly_sel,
  output logic             dout_valid,
  output logic [WIDTH-1:0] doutput,
  output logic             busy,
  output logic [DW-1:0]    cur_dly,
  output logic             load_err
);

  if (!ndelay_params_ok(MAX_DELAYS, DELAYS)) begin : g_param_check
    $error("ndelay_ctrl: need MAX_DELAYS >= 2 and 1 <= DELAYS <= MAX_DELAYS");
  end

  logic [WIDTH-1:0]      tapData [MAX_DELAYS];
  logic [MAX_DELAYS-1:0] tapValid;
  logic [DW-1:0]         curDly_q, curDly_d;
  logic                  loadErr_q, loadErr_d;
  logic                  busyC;
  logic                  selInRange;
  logic                  loadAccept;
  logic                  loadReject;
  logic [WIDTH-1:0]      doutC;
  logic                  doutValidC;

  for (genvar g = 0; g < MAX_DELAYS; g++) begin : g_tap
    if (g == 0) begin : g_head
      ndelay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr_valid (flush),
        .d         (dinput),
        .dv        (din_valid),
        .q         (tapData[g]),
        .qv        (tapValid[g])
      );
    end else begin : g_body
      // An accepted load empties everything past tap 0 so stale words never resurface.
      ndelay_stage #(.WIDTH(WIDTH)) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr_valid (flush | loadAccept),
        .d         (tapData[g-1]),
        .dv        (tapValid[g-1]),
        .q         (tapData[g]),
        .qv        (tapValid[g])
      );
    end
  end

  always_comb begin
    busyC      = 1'b0;
    doutC      = '0;
    doutValidC = 1'b0;
    for (int i = 0; i < MAX_DELAYS; i++) begin
      if (DW'(i) < curDly_q) busyC = busyC | tapValid[i];
      if (DW'(i + 1) == curDly_q) begin
        doutC      = tapData[i];
        doutValidC = tapValid[i];
      end
    end
  end

  // Flush outranks a load request, and swallows it without flagging an error.
  always_comb begin
    selInRange = (dly_sel >= DW'(DLY_MIN)) && (dly_sel <= DW'(MAX_DELAYS));
    loadAccept = dly_load & ~flush & ~busyC & selInRange;
    loadReject = dly_load & ~flush & ~loadAccept;
    curDly_d   = curDly_q;
    if (loadAccept) curDly_d = dly_sel;
    loadErr_d  = loadReject;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      curDly_q  <= DW'(DELAYS);
      loadErr_q <= 1'b0;
    end else begin
      curDly_q  <= curDly_d;
      loadErr_q <= loadErr_d;
    end
  end

  assign doutput    = doutC;
  assign dout_valid = doutValidC;
  assign busy       = busyC;
  assign cur_dly    = curDly_q;
  assign load_err   = loadErr_q;

endmodule
